ram_dual_write_ctrl: RTL
========================

Name: ram_dual_write_ctrl

Overview:
Write-side front end for ram_dual. Accepts a valid/ready byte stream in the write_clock domain and drives ram_dual's data/write_addr/we write port. Maintains a Gray-coded write pointer for the read-domain consumer and synchronizes the read-domain Gray pointer back, so it can flag full/almost-full and never overwrite unread words. Together the two blocks form the write half of an async FIFO built around ram_dual.

Parameters:
DATA_WIDTH, 8, stream and RAM data width (matches ram_dual data/q)
ADDR_WIDTH, 6, RAM address width; DEPTH = 2**ADDR_WIDTH = 64 words
SYNC_STAGES, 2, flop stages on the incoming read pointer (legal values 2..4)
AF_LEVEL, 60, occupancy at or above which almost_full asserts (1..DEPTH)

Ports:
write_clock  in  1  sole clock; all logic on its rising edge
reset  in  1  asynchronous, active-high; clears all state
in_data  in  DATA_WIDTH  stream data
in_valid  in  1  in_data valid
in_ready  out  1  block can accept; equals ~full
rd_ptr_gray  in  ADDR_WIDTH+1  read-domain Gray pointer, asynchronous to write_clock
data  out  DATA_WIDTH  to ram_dual.data
write_addr  out  ADDR_WIDTH  to ram_dual.write_addr
we  out  1  to ram_dual.we
wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, for the read domain
full  out  1  DEPTH words outstanding
almost_full  out  1  level >= AF_LEVEL
level  out  ADDR_WIDTH+1  write-side occupancy estimate, 0..DEPTH

Behaviour:
- Reset (async assert, sync release): wr_bin=0, wr_ptr_gray=0, sync flops=0, data=0, write_addr=0, we=0, full=0, almost_full=0, level=0. in_ready=1 after release. The cycle after release accepts normally.
- Accept = in_valid & in_ready. When in_ready=0, in_valid is ignored. No data is dropped or duplicated.
- On accept at edge N:
  - data<=in_data, write_addr<=wr_bin[ADDR_WIDTH-1:0], we<=1, all visible after edge N. This gives a 1-cycle registered latency to the RAM port.
  - wr_bin<=wr_bin+1, modulo 2**(ADDR_WIDTH+1).
  - wr_ptr_gray<=bin2gray(wr_bin+1). Exactly one bit changes per accept.
- No accept: we<=0. data and write_addr hold.
- Read-pointer sync: rd_ptr_gray passes through SYNC_STAGES flops, then gray2bin gives rd_bin_s. No other logic samples rd_ptr_gray.
- Every edge, with wr_bin_nx = the post-update wr_bin:
  - level<=wr_bin_nx - rd_bin_s, computed modulo 2**(ADDR_WIDTH+1).
  - full<=(level_nx==DEPTH).
  - almost_full<=(level_nx>=AF_LEVEL).
- Wrap-around: the address wraps 63->0 while pointer bit ADDR_WIDTH toggles. full is judged on the difference only, so pointer wrap 127->0 is transparent.
- Full: asserts on the edge of the DEPTH-th outstanding accept, so in_ready drops the next cycle. There is never an accept while full.
- Full release: a read-pointer advance seen at an edge clears full SYNC_STAGES+1 edges later (3 by default). This latency is conservative: full may linger but never asserts late.
- Simultaneous accept and read-pointer advance in one cycle: level reflects both. Net unchanged if both advance by 1.
- Reset mid-burst: outputs clear immediately (async) and we drops without waiting for a clock. The stream restarts at address 0. The read side must be reset together.
- Overflow of level beyond DEPTH cannot occur. The bench asserts level<=DEPTH on every edge.

Decomposition:
- Package ram_dual_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults, DEPTH.
  - Pointer typedef ptr_t (ADDR_WIDTH+1 bits).
  - Functions bin2gray and gray2bin, shared with the future read controller.
- Sub-module ptr_sync: a SYNC_STAGES-deep multi-bit flop synchronizer with async reset to 0. It is reused by the read-side controller.

Test Plan:
- Reset then idle (in_valid=0, rd_ptr_gray=0) -> we=0, in_ready=1, level=0, full=0, almost_full=0, wr_ptr_gray=0.
- Stream 0x00..0x3F back-to-back with rd_ptr_gray held at 0 -> 64 we pulses at write_addr 0..63 with data equal to the address, one cycle after each accept. almost_full rises after the 60th accept; full rises after the 64th; in_ready=0 from then on; the 65th word is held off; level=64; wr_ptr_gray=bin2gray(64)=7'h60.
- From full, drive rd_ptr_gray=bin2gray(4) -> full falls exactly 3 edges later, level=60, almost_full stays 1. Four more words go to addresses 0..3.
- Long run of 300 words with a read model consuming 1 per 2 cycles -> addresses wrap 63->0 repeatedly. wr_ptr_gray changes exactly one bit per accept. Data order matches an ideal queue; no overwrite of unread words.
- Same-cycle accept and rd pointer step at level=30 -> level stays 30 after sync latency. Across a 10-cycle window of mixed events, the final level equals accepts minus reads.
- Assert reset at a mid-edge point during a burst, write_addr=0x15 -> we=0 and all outputs 0 immediately. After release, the first accepted word goes to write_addr 0.

Source files
------------

// File: rtl/ram_dual_pkg.sv
// Shared definitions for the ram_dual async FIFO controllers: widths,
// the pointer type and the Gray-code conversions used by both clock domains.
package ram_dual_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

  // One extra bit beyond the address distinguishes full from empty.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[DEF_ADDR_WIDTH] = g[DEF_ADDR_WIDTH];
    for (int i = DEF_ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ram_dual_write_ctrl_ptr_sync.sv
// Multi-bit flop synchronizer for a Gray-coded pointer crossing clock domains.
// Safe only because the source changes at most one bit per update.
module ptr_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // NOTE: this array is a shift chain of real flops, not a RAM, so every
  // stage is reset; a stale pointer here would corrupt occupancy after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ram_dual_write_ctrl.sv
// Write-side front end of the ram_dual async FIFO: accepts a valid/ready byte
// stream, drives the RAM write port and tracks occupancy against the read pointer.
module ram_dual_write_ctrl
  import ram_dual_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 60
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int                FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_PTR = FIFO_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_PTR    = AF_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0]   r_wr_bin;
  logic [ADDR_WIDTH:0]   r_wr_ptr_gray;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic                  r_we;
  logic                  r_full;
  logic                  r_almost_full;
  logic [ADDR_WIDTH:0]   r_level;

  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_wr_bin_nx;
  logic [ADDR_WIDTH:0]   w_rd_gray_s;
  logic [ADDR_WIDTH:0]   w_rd_bin_s;
  logic [ADDR_WIDTH:0]   w_level_nx;

  ptr_sync #(
    .WIDTH  (ADDR_WIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .i_clk (write_clock),
    .i_rst (reset),
    .i_d   (rd_ptr_gray),
    .o_q   (w_rd_gray_s)
  );

  assign w_accept    = in_valid & ~r_full;
  assign w_wr_bin_nx = r_wr_bin + {{ADDR_WIDTH{1'b0}}, w_accept};
  assign w_rd_bin_s  = gray2bin(w_rd_gray_s);
  // Modular difference makes the 127->0 pointer wrap invisible to occupancy.
  assign w_level_nx  = w_wr_bin_nx - w_rd_bin_s;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge write_clock or posedge reset) begin
    if (reset) begin
      r_wr_bin      <= '0;
      r_wr_ptr_gray <= '0;
      r_data        <= '0;
      r_write_addr  <= '0;
      r_we          <= 1'b0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_data        <= in_data;
        r_write_addr  <= r_wr_bin[ADDR_WIDTH-1:0];
        r_wr_ptr_gray <= bin2gray(w_wr_bin_nx);
      end
      r_wr_bin      <= w_wr_bin_nx;
      r_level       <= w_level_nx;
      r_full        <= (w_level_nx == DEPTH_PTR);
      r_almost_full <= (w_level_nx >= AF_PTR);
    end
  end

  assign in_ready    = ~r_full;
  assign data        = r_data;
  assign write_addr  = r_write_addr;
  assign we          = r_we;
  assign wr_ptr_gray = r_wr_ptr_gray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign level       = r_level;

endmodule
